// File: rtl/telemetry_buffer.sv
// Telemetry sampler feeding a first-word-fall-through FIFO.
// Samples {timestamp, velocity, altitude, distance, stage} every INTERVAL enabled cycles.
// Optional build macro TELEMETRY_STAGE_TRIGGER_EN adds an immediate sample on every stage change
// and restarts the interval count from that point.
module telemetry_buffer #(
  parameter int unsigned N        = 64,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned INTERVAL = 1000
) (
  input  logic                       clk,
  input  logic                       resetb,
  input  logic                       enable,
  input  logic [N-1:0]               velocity,
  input  logic [N-1:0]               current_altitude,
  input  logic [N-1:0]               current_distance,
  input  logic [3:0]                 stage,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [31:0]                out_time,
  output logic [N-1:0]               out_velocity,
  output logic [N-1:0]               out_altitude,
  output logic [N-1:0]               out_distance,
  output logic [3:0]                 out_stage,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned IW = $clog2(INTERVAL);
  localparam int unsigned EW = 32 + 3 * N + 4;

  logic [31:0]    ts_q;
  logic [IW-1:0]  icnt_q;
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q, count_d;
  logic           ovf_q;
  logic [EW-1:0]  mem [DEPTH];
  logic [EW-1:0]  head;

  logic periodic, strobe, full, pop, push;

  assign periodic = enable && (icnt_q == IW'(INTERVAL - 1));

`ifdef TELEMETRY_STAGE_TRIGGER_EN
  logic [3:0] prev_stage_q;
  logic       stage_trig;

  assign stage_trig = enable && (stage != prev_stage_q);
  // Coinciding periodic and stage triggers collapse into one strobe, hence one push.
  assign strobe     = periodic || stage_trig;

  // Previous stage tracker used to detect stage changes.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) prev_stage_q <= 4'd0;
    else         prev_stage_q <= stage;
  end
`else
  assign strobe = periodic;
`endif

  assign full = (count_q == CW'(DEPTH));
  assign pop  = (count_q != '0) && out_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push = strobe && (!full || pop);

  // Occupancy next-state from the push/pop pair.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Timestamp, interval counter, pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      ts_q     <= 32'd0;
      icnt_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      ts_q <= ts_q + 32'd1;
      if (!enable || strobe) icnt_q <= '0;
      else                   icnt_q <= icnt_q + IW'(1);
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      if (strobe && full && !pop) ovf_q <= 1'b1;
    end
  end

  // Entry storage; contents are meaningless whenever count is zero, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {ts_q, velocity, current_altitude, current_distance, stage};
  end

  // Head entry presented directly from storage, forced to zero while empty.
  always_comb begin
    head         = out_valid ? mem[rd_ptr_q] : '0;
    out_time     = head[EW-1 -: 32];
    out_velocity = head[3*N+3 -: N];
    out_altitude = head[2*N+3 -: N];
    out_distance = head[N+3 -: N];
    out_stage    = head[3:0];
  end

  assign out_valid = (count_q != '0);
  assign count     = count_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_telemetry_buffer.sv
// Directed bench for telemetry_buffer with INTERVAL=4, DEPTH=4, N=16.
module tb_telemetry_buffer;

  localparam int unsigned N = 16;

  logic          clk = 1'b0;
  logic          resetb = 1'b1;
  logic          enable = 1'b0;
  logic [N-1:0]  velocity = '0;
  logic [N-1:0]  current_altitude = '0;
  logic [N-1:0]  current_distance = '0;
  logic [3:0]    stage = 4'd0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [31:0]   out_time;
  logic [N-1:0]  out_velocity, out_altitude, out_distance;
  logic [3:0]    out_stage;
  logic [2:0]    count;
  logic          overflow;

  int n_checks = 0;
  int n_fail   = 0;

  telemetry_buffer #(.N(N), .DEPTH(4), .INTERVAL(4)) dut (
    .clk              (clk),
    .resetb           (resetb),
    .enable           (enable),
    .velocity         (velocity),
    .current_altitude (current_altitude),
    .current_distance (current_distance),
    .stage            (stage),
    .out_ready        (out_ready),
    .out_valid        (out_valid),
    .out_time         (out_time),
    .out_velocity     (out_velocity),
    .out_altitude     (out_altitude),
    .out_distance     (out_distance),
    .out_stage        (out_stage),
    .count            (count),
    .overflow         (overflow)
  );

  initial forever #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Assert reset mid-cycle, check cleared state, release on a falling edge.
  task automatic do_reset();
    #2 resetb = 1'b0;
    #1;
    check_eq("rst_count", count, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_ovf", overflow, 0);
    check_eq("rst_time", out_time, 0);
    @(negedge clk);
    resetb = 1'b1;
  endtask

  initial begin
    // Periodic sampling with a consumer that always accepts.
    enable = 1'b1; out_ready = 1'b1; velocity = 16'd100;
    current_altitude = 16'd5; current_distance = 16'd7; stage = 4'd0;
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      step(1);
      check_eq("t1_valid", out_valid, (k % 4 == 0));
      if (k % 4 == 0) begin
        check_eq("t1_time", out_time, k - 1);
        check_eq("t1_vel", out_velocity, 100);
      end
    end

    // Fill, overflow, then drain in order.
    out_ready = 1'b0;
    do_reset();
    step(16);
    check_eq("t2_count_full", count, 4);
    check_eq("t2_ovf_before", overflow, 0);
    step(4);
    check_eq("t2_ovf_after", overflow, 1);
    check_eq("t2_count_keep", count, 4);
    check_eq("t2_head0", out_time, 3);
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step(1);
      check_eq("t2_drain", out_time, 3 + 4 * i);
    end
    out_ready = 1'b0;

    // Push and pop on the same edge while full.
    do_reset();
    step(19);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    check_eq("t3_count", count, 4);
    check_eq("t3_ovf", overflow, 0);
    check_eq("t3_head", out_time, 7);
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step(1);
      check_eq("t3_drain", out_time, 7 + 4 * i);
    end

    // Enable gap restarts the interval count.
    enable = 1'b1; out_ready = 1'b1;
    do_reset();
    step(2);
    enable = 1'b0;
    for (int k = 3; k <= 5; k++) begin
      step(1);
      check_eq("t4_gap_valid", out_valid, 0);
    end
    enable = 1'b1;
    for (int k = 6; k <= 8; k++) begin
      step(1);
      check_eq("t4_wait_valid", out_valid, 0);
    end
    step(1);
    check_eq("t4_valid", out_valid, 1);
    check_eq("t4_time", out_time, 8);

    // Asynchronous reset mid-cycle with entries and overflow pending.
    out_ready = 1'b0;
    do_reset();
    step(20);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    check_eq("t5_count_pre", count, 3);
    check_eq("t5_ovf_pre", overflow, 1);
    #2 resetb = 1'b0;
    #1;
    check_eq("t5_count", count, 0);
    check_eq("t5_valid", out_valid, 0);
    check_eq("t5_ovf", overflow, 0);
    check_eq("t5_time", out_time, 0);
    @(negedge clk);
    resetb = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step(1);
      check_eq("t5_post_valid", out_valid, 0);
    end

    // Stage change 1 -> 2.
    stage = 4'd1; enable = 1'b1; out_ready = 1'b0;
    do_reset();
    step(2);
    stage = 4'd2;
    step(1);
`ifdef TELEMETRY_STAGE_TRIGGER_EN
    check_eq("t6_count_trig", count, 2);
    step(3);
    check_eq("t6_count_hold", count, 2);
    step(1);
    check_eq("t6_count_per", count, 3);
    check_eq("t6_time0", out_time, 0);
    check_eq("t6_stage0", out_stage, 1);
    out_ready = 1'b1;
    step(1);
    check_eq("t6_time1", out_time, 2);
    check_eq("t6_stage1", out_stage, 2);
    step(1);
    check_eq("t6_time2", out_time, 6);
    check_eq("t6_stage2", out_stage, 2);
`else
    check_eq("t6_no_trig", count, 0);
    step(1);
    check_eq("t6_count_per", count, 1);
    check_eq("t6_time", out_time, 3);
    check_eq("t6_stage", out_stage, 2);
    step(3);
    check_eq("t6_count_hold", count, 1);
    step(1);
    check_eq("t6_count_next", count, 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
